// File: rtl/tx_pause_pkg.sv
// rtl/tx_pause_pkg.sv - shared types, constants and pause word builder for the pause frame inserter
package tx_pause_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_PAUSE
    } state_e;

    localparam int          PAUSE_WORDS      = 8;
    localparam logic [2:0]  PAUSE_LAST_EMPTY = 3'd4;

    localparam logic [47:0] DEF_PAUSE_DA     = 48'h0180C2000001;
    localparam logic [15:0] DEF_PAUSE_TYPE   = 16'h8808;
    localparam logic [15:0] DEF_PAUSE_OPCODE = 16'h0001;

    // 60-byte MAC-control frame, MSB-first; words 3..7 are zero padding
    function automatic logic [63:0] pause_word(
        input logic [2:0]  n,
        input logic [47:0] sa,
        input logic [15:0] quanta,
        input logic [47:0] da,
        input logic [15:0] etype,
        input logic [15:0] opcode
    );
        logic [63:0] w;
        case (n)
            3'd0:    w = {da, sa[47:32]};
            3'd1:    w = {sa[31:0], etype, opcode};
            3'd2:    w = {quanta, 48'h0};
            default: w = 64'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tx_pause_word_rom.sv
// rtl/tx_pause_word_rom.sv - combinational generator of the eight pause frame data words
module tx_pause_word_rom
    import tx_pause_pkg::*;
#(
    parameter logic [47:0] PAUSE_DA     = DEF_PAUSE_DA,
    parameter logic [15:0] PAUSE_TYPE   = DEF_PAUSE_TYPE,
    parameter logic [15:0] PAUSE_OPCODE = DEF_PAUSE_OPCODE
) (
    input  logic [2:0]  wcnt_i,
    input  logic [47:0] sa_i,
    input  logic [15:0] quanta_i,
    output logic [63:0] word_o
);

    assign word_o = pause_word(wcnt_i, sa_i, quanta_i, PAUSE_DA, PAUSE_TYPE, PAUSE_OPCODE);

endmodule

// File: rtl/tx_st_pause_frame_inserter.sv
// rtl/tx_st_pause_frame_inserter.sv - merges client TX packets with PAUSE frames at packet boundaries
module tx_st_pause_frame_inserter
    import tx_pause_pkg::*;
#(
    parameter logic [47:0] PAUSE_DA     = DEF_PAUSE_DA,
    parameter logic [15:0] PAUSE_TYPE   = DEF_PAUSE_TYPE,
    parameter logic [15:0] PAUSE_OPCODE = DEF_PAUSE_OPCODE
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        in_error,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [2:0]  in_empty,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_error,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [2:0]  out_empty,
    input  logic        pause_req,
    input  logic [15:0] pause_quanta,
    input  logic [47:0] mac_src_addr,
    output logic        pause_busy,
    output logic        pause_sent
);

    state_e      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic        pend_q, pend_d;
    logic [15:0] quanta_q, quanta_d;
    logic [15:0] frame_quanta_q, frame_quanta_d;
    logic        sent_q, sent_d;
    logic [63:0] pause_data;
    logic        pass;

    tx_pause_word_rom #(
        .PAUSE_DA     (PAUSE_DA),
        .PAUSE_TYPE   (PAUSE_TYPE),
        .PAUSE_OPCODE (PAUSE_OPCODE)
    ) u_rom (
        .wcnt_i   (wcnt_q),
        .sa_i     (mac_src_addr),
        .quanta_i (frame_quanta_q),
        .word_o   (pause_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= 3'd0;
            pend_q         <= 1'b0;
            quanta_q       <= 16'h0;
            frame_quanta_q <= 16'h0;
            sent_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            pend_q         <= pend_d;
            quanta_q       <= quanta_d;
            frame_quanta_q <= frame_quanta_d;
            sent_q         <= sent_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        wcnt_d            = wcnt_q;
        pend_d            = pend_q | pause_req;
        quanta_d          = pause_req ? pause_quanta : quanta_q;
        frame_quanta_d    = frame_quanta_q;
        sent_d            = 1'b0;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        out_data          = 64'h0;
        out_error         = 1'b0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_empty         = 3'd0;
        pass              = (state_q == ST_PKT) || (state_q == ST_IDLE && !pend_q);

        case (state_q)
            ST_IDLE: begin
                // a request arriving in the hand-off cycle is folded into this frame
                if (pend_q) begin
                    state_d        = ST_PAUSE;
                    wcnt_d         = 3'd0;
                    frame_quanta_d = quanta_d;
                    pend_d         = 1'b0;
                end else if (in_valid && out_ready && in_startofpacket && !in_endofpacket) begin
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                if (in_valid && out_ready && in_endofpacket) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                out_valid         = 1'b1;
                out_data          = pause_data;
                out_startofpacket = (wcnt_q == 3'd0);
                out_endofpacket   = (wcnt_q == 3'(PAUSE_WORDS - 1));
                out_empty         = out_endofpacket ? PAUSE_LAST_EMPTY : 3'd0;
                if (out_ready) begin
                    wcnt_d = wcnt_q + 3'd1;
                    if (wcnt_q == 3'(PAUSE_WORDS - 1)) begin
                        state_d = ST_IDLE;
                        sent_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // gating with reset_n keeps the stream quiet while reset is held
        if (pass && reset_n) begin
            in_ready          = out_ready;
            out_valid         = in_valid;
            out_data          = in_data;
            out_error         = in_error;
            out_startofpacket = in_startofpacket;
            out_endofpacket   = in_endofpacket;
            out_empty         = in_empty;
        end
    end

    assign pause_busy = pend_q || (state_q == ST_PAUSE);
    assign pause_sent = sent_q;

endmodule

// File: tb/tb_tx_st_pause_frame_inserter.sv
// tb/tb_tx_st_pause_frame_inserter.sv - directed self-checking bench for the pause frame inserter
module tb_tx_st_pause_frame_inserter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_ready;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_error;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [2:0]  in_empty;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_error;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [2:0]  out_empty;
    logic        pause_req;
    logic [15:0] pause_quanta;
    logic [47:0] mac_src_addr;
    logic        pause_busy;
    logic        pause_sent;

    int checks   = 0;
    int failures = 0;

    tx_st_pause_frame_inserter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .pause_req         (pause_req),
        .pause_quanta      (pause_quanta),
        .mac_src_addr      (mac_src_addr),
        .pause_busy        (pause_busy),
        .pause_sent        (pause_sent)
    );

    always #5 clk = ~clk;

    // SA is fixed at 48'h001122334455 throughout, so w0/w1 are hand-computed constants
    function automatic logic [63:0] exp_word(input int n, input logic [15:0] q);
        case (n)
            0:       return 64'h0180C20000010011;
            1:       return 64'h2233445588080001;
            2:       return {q, 48'h0};
            default: return 64'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop,
                              input logic err, input logic [2:0] emp);
        in_valid         = 1'b1;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_error         = err;
        in_empty         = emp;
    endtask

    task automatic idle_client();
        in_valid         = 1'b0;
        in_data          = 64'h0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 1'b0;
        in_empty         = 3'd0;
    endtask

    // Consumes one pause frame; called with the request already registered
    task automatic run_pause(input logic [15:0] q, input bit stall, input bit hold_client);
        int          idx = 0;
        int          cyc = 0;
        bit          prev_stalled = 0;
        logic [63:0] prev_data = 64'h0;
        while (idx < 8 && cyc < 200) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hold_client) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_in_ready beat=%0d got=%b exp=0", idx, in_ready);
                end
            end
            if (out_valid) begin
                checks++;
                if (pause_sent !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_sent_early beat=%0d got=%b exp=0", idx, pause_sent);
                end
                if (prev_stalled) begin
                    checks++;
                    if (out_data !== prev_data) begin
                        failures++;
                        $display("FAIL stall_hold beat=%0d got=%h exp=%h", idx, out_data, prev_data);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (out_data !== exp_word(idx, q)) begin
                        failures++;
                        $display("FAIL pause_word%0d got=%h exp=%h", idx, out_data, exp_word(idx, q));
                    end
                    checks++;
                    if ({out_startofpacket, out_endofpacket, out_empty, out_error} !==
                        {1'(idx == 0), 1'(idx == 7), (idx == 7) ? 3'd4 : 3'd0, 1'b0}) begin
                        failures++;
                        $display("FAIL pause_ctrl%0d got sop=%b eop=%b empty=%0d err=%b exp sop=%b eop=%b empty=%0d err=0",
                                 idx, out_startofpacket, out_endofpacket, out_empty, out_error,
                                 idx == 0, idx == 7, (idx == 7) ? 4 : 0);
                    end
                    idx++;
                    prev_stalled = 0;
                end else begin
                    prev_stalled = 1;
                    prev_data    = out_data;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (idx != 8) begin
            failures++;
            $display("FAIL pause_timeout got beats=%0d exp=8", idx);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (pause_sent !== 1'b1) begin
            failures++;
            $display("FAIL pause_sent_pulse got=%b exp=1", pause_sent);
        end
        step();
        checks++;
        if ({pause_sent, pause_busy} !== 2'b00) begin
            failures++;
            $display("FAIL pause_after got sent=%b busy=%b exp sent=0 busy=0", pause_sent, pause_busy);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive_beat(64'h1111, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        step();
        checks++;
        if ({out_valid, in_ready, pause_busy, pause_sent} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b ready=%b busy=%b sent=%b exp all 0",
                     out_valid, in_ready, pause_busy, pause_sent);
        end
        idle_client();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(64'hA0A0_0000_0000_0000 + 64'(i), 1'(i == 0), 1'(i == 2), 1'(i == 1),
                       (i == 2) ? 3'd3 : 3'd0);
            #1;
            checks++;
            if ({out_valid, in_ready, out_data, out_error, out_startofpacket, out_endofpacket, out_empty} !==
                {2'b11, 64'hA0A0_0000_0000_0000 + 64'(i), 1'(i == 1), 1'(i == 0), 1'(i == 2),
                 (i == 2) ? 3'd3 : 3'd0}) begin
                failures++;
                $display("FAIL pass_beat%0d got v=%b r=%b d=%h e=%b s=%b p=%b m=%0d", i,
                         out_valid, in_ready, out_data, out_error, out_startofpacket,
                         out_endofpacket, out_empty);
            end
            step();
        end
        idle_client();
        out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL pass_idle got valid=%b ready=%b exp 0 0", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_pause_idle();
        pause_quanta = 16'hFFFF;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        checks++;
        if ({pause_busy, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL idle_pend got busy=%b valid=%b exp busy=1 valid=0", pause_busy, out_valid);
        end
        run_pause(16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_pause_mid_packet();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(64'hB000 + 64'(i), 1'(i == 0), 1'(i == 4), 1'b0, 3'd0);
            pause_req    = (i == 1);
            pause_quanta = 16'h1234;
            #1;
            checks++;
            if ({out_valid, in_ready, out_data, out_startofpacket, out_endofpacket} !==
                {2'b11, 64'hB000 + 64'(i), 1'(i == 0), 1'(i == 4)}) begin
                failures++;
                $display("FAIL midpkt_beat%0d got v=%b r=%b d=%h s=%b e=%b", i,
                         out_valid, in_ready, out_data, out_startofpacket, out_endofpacket);
            end
            step();
        end
        pause_req = 1'b0;
        idle_client();
        run_pause(16'h1234, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        out_ready = 1'b1;
        drive_beat(64'hC000, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        idle_client();
        pause_quanta = 16'h0005;
        pause_req    = 1'b1;
        step();
        pause_quanta = 16'h0009;
        step();
        pause_req = 1'b0;
        drive_beat(64'hC001, 1'b0, 1'b1, 1'b0, 3'd2);
        #1;
        checks++;
        if ({out_valid, out_endofpacket, out_data, pause_busy} !== {2'b11, 64'hC001, 1'b1}) begin
            failures++;
            $display("FAIL b2b_eop got v=%b e=%b d=%h busy=%b", out_valid, out_endofpacket, out_data, pause_busy);
        end
        step();
        idle_client();
        run_pause(16'h0009, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) extra++;
            step();
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL b2b_single_frame got extra_valid=%0d exp=0", extra);
        end
    endtask

    task automatic test_random_ready();
        pause_quanta = 16'hABCD;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        drive_beat(64'hDEAD, 1'b1, 1'b1, 1'b0, 3'd0);
        run_pause(16'hABCD, 1'b1, 1'b1);
        idle_client();
        step();
    endtask

    task automatic test_reset_mid_pause();
        out_ready    = 1'b1;
        pause_quanta = 16'h0007;
        pause_req    = 1'b1;
        step();
        pause_req = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({out_valid, out_startofpacket, out_endofpacket, pause_busy} !== 4'b1001) begin
            failures++;
            $display("FAIL rst_w4 got v=%b s=%b e=%b busy=%b exp 1 0 0 1",
                     out_valid, out_startofpacket, out_endofpacket, pause_busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, pause_busy} !== 3'b000) begin
            failures++;
            $display("FAIL rst_immediate got v=%b r=%b busy=%b exp 0 0 0", out_valid, in_ready, pause_busy);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            drive_beat(64'hE000 + 64'(i), 1'(i == 0), 1'(i == 1), 1'b0, 3'd0);
            #1;
            checks++;
            if ({out_valid, in_ready, out_data, pause_busy} !== {2'b11, 64'hE000 + 64'(i), 1'b0}) begin
                failures++;
                $display("FAIL rst_after_beat%0d got v=%b r=%b d=%h busy=%b", i,
                         out_valid, in_ready, out_data, pause_busy);
            end
            step();
        end
        idle_client();
    endtask

    initial begin
        reset_n      = 1'b0;
        out_ready    = 1'b1;
        pause_req    = 1'b0;
        pause_quanta = 16'h0;
        mac_src_addr = 48'h001122334455;
        idle_client();
        test_reset();
        test_passthrough();
        test_pause_idle();
        test_pause_mid_packet();
        test_back_to_back();
        test_random_ready();
        test_reset_mid_pause();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_st_pause_frame_inserter.md
Name: tx_st_pause_frame_inserter

Overview:
- Avalon-ST TX stage placed directly upstream of the TX pause-control error adapter.
- Merges the client TX packet stream with MAC-generated 802.3x PAUSE frames, inserting them only at packet boundaries.
- Output is a 64-bit, 1-bit-error stream that feeds the error adapter.
- Pause frames are 60 bytes, unpadded-complete; the downstream CRC stage appends the FCS.

Parameters:
- PAUSE_DA, 48'h0180C2000001, destination MAC for PAUSE frames.
- PAUSE_TYPE, 16'h8808, MAC-control EtherType.
- PAUSE_OPCODE, 16'h0001, MAC-control opcode.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- in_ready  out  1  client stream ready.
- in_valid  in  1  client stream valid.
- in_data  in  64  client data; first byte on [63:56].
- in_error  in  1  client error.
- in_startofpacket  in  1  client SOP.
- in_endofpacket  in  1  client EOP.
- in_empty  in  3  client empty bytes on the EOP beat.
- out_ready  in  1  downstream ready.
- out_valid  out  1  merged stream valid.
- out_data  out  64  merged stream data.
- out_error  out  1  merged stream error.
- out_startofpacket  out  1  merged stream SOP.
- out_endofpacket  out  1  merged stream EOP.
- out_empty  out  3  merged stream empty.
- pause_req  in  1  one-cycle request to send a PAUSE frame.
- pause_quanta  in  16  quanta sampled with pause_req; 0 = XON.
- mac_src_addr  in  48  station address; must be stable while the block is in PAUSE.
- pause_busy  out  1  high while a request is pending or a frame is being emitted.
- pause_sent  out  1  one-cycle pulse on acceptance of the PAUSE EOP beat.

Behaviour:
- Beat transfer rule: a beat transfers when out_valid && out_ready.
- States:
  - IDLE: between packets.
  - PKT: inside a client packet.
  - PAUSE: emitting pause beats; a 3-bit counter wcnt runs 0..7.
- Reset (async, reset_n low):
  - state=IDLE, wcnt=0, pend=0, quanta register=0, pause_sent=0.
  - Outputs are combinational from state, so out_valid=0 and in_ready=0 follow while reset is held.
- Pending request: pause_req sets pend and loads the quanta register in any state. A request while pend=1 overwrites quanta; the latest request wins and only one frame is sent.
- IDLE, pend=0:
  - Combinational pass-through with zero latency: in_ready=out_ready, out_* = in_*.
  - An accepted SOP beat without EOP goes to PKT.
  - An accepted SOP+EOP beat stays in IDLE.
- IDLE, pend=1:
  - Pause has priority. in_ready=0.
  - Next cycle: state=PAUSE, wcnt=0, frame quanta frozen from the quanta register, pend cleared.
  - pend is also cleared if a new pause_req arrives in that same cycle, and its quanta is used.
- PKT:
  - Pass-through as in IDLE.
  - An accepted EOP beat returns to IDLE.
  - Pending requests wait; a client packet is never split.
- PAUSE:
  - in_ready=0, out_valid=1, out_error=0.
  - SOP=1 on wcnt=0; EOP=1 and empty=4 on wcnt=7; otherwise empty=0.
  - wcnt advances on each accepted beat.
  - On acceptance of wcnt=7: pause_sent=1 for one cycle, then go to IDLE. A pend raised during emission triggers another frame from IDLE.
- Pause frame beats (bytes MSB-first):
  - w0 = DA[47:0], SA[47:32].
  - w1 = SA[31:0], PAUSE_TYPE, PAUSE_OPCODE.
  - w2 = quanta[15:0], 48'h0.
  - w3..w6 = 0.
  - w7 = 0, with bytes 4..7 treated as empty.
- Backpressure: when out_ready=0 in PAUSE, out_data/wcnt hold stable and out_valid stays 1.
- Malformed input: non-SOP beats in IDLE pass through and state is unchanged. A SOP beat in PKT passes through; the block does not repair framing.
- Reset mid-packet or mid-pause: the frame is abandoned, and downstream sees a truncated stream, which is acceptable.
- pause_busy = pend || (state==PAUSE).

Decomposition:
- Shared package tx_pause_pkg:
  - state enum (IDLE/PKT/PAUSE).
  - PAUSE_WORDS=8 and PAUSE_LAST_EMPTY=3'd4.
  - Default DA/type/opcode constants.
  - A function returning pause word n given SA and quanta.
- One sub-module, tx_pause_word_rom: combinational word generator. The FSM and mux stay in the top.

Test Plan:
- Idle pass-through: a 3-beat packet with out_ready=1 appears unchanged in the same cycles; in_error on beat 2 passes through.
- pause_req (quanta=16'hFFFF, SA=48'h001122334455) in IDLE produces 8 beats:
  - w0=64'h0180C20000010011, w1=64'h2233445588080001, w2=64'hFFFF000000000000.
  - w7 carries EOP, empty=4; pause_sent pulses once.
- pause_req during beat 2 of a 5-beat packet: the packet completes uninterrupted, and the pause SOP is the next output beat after EOP.
- Back-to-back requests quanta=5 then quanta=9 before the IDLE boundary: exactly one frame is sent, with w2[63:48]=16'h0009.
- Random out_ready toggling during PAUSE: no beat is lost or duplicated, data is stable while stalled, and in_ready stays 0 throughout.
- Assert reset_n at wcnt=4: out_valid=0 immediately; after release, a fresh client packet passes with pause_busy=0.
